// File: rtl/rx_block_assembler.sv
// Purpose : rebuild BLOCK_BYTES received bytes into one block, optionally checking a trailing CRC-8.
// Latency : block_valid rises one clock after the final strobe (last data byte, or the CRC byte).
// Backpr. : block is held until block_valid && block_ready; bytes arriving meanwhile are dropped (overrun).
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   crc_en            frame carries a trailing CRC byte (sampled on the first byte of a frame)
//   rx_data/rx_valid  byte stream from the UART receiver, one-cycle strobe
//   block_ready       downstream accept
//   block_out         assembled block, first byte in the top byte lane
//   block_valid       block_out/crc_err valid, held until accepted
//   crc_err           received CRC differs from computed CRC (0 for frames without CRC)
//   overrun           one-cycle pulse: byte dropped while a block was held
//   frame_abort       one-cycle pulse: inter-byte timeout discarded a partial frame
//   busy              a frame is in progress or a block is held
module rx_block_assembler #(
  parameter int unsigned BLOCK_BYTES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CRC_POLY       = 8'h07
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       crc_en,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       block_ready,
  output logic [8*BLOCK_BYTES-1:0]   block_out,
  output logic                       block_valid,
  output logic                       crc_err,
  output logic                       overrun,
  output logic                       frame_abort,
  output logic                       busy
);

  localparam int unsigned BW    = 8 * BLOCK_BYTES;
  localparam int unsigned CNT_W = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CRC, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       crc_q, crc_d;
  logic             frame_crc_q, frame_crc_d;
  logic             crc_err_q, crc_err_d;
  logic             overrun_q, overrun_d;
  logic             abort_q, abort_d;

  // CRC-8, MSB first, applied to (crc ^ byte).
  function automatic logic [7:0] crc8(input logic [7:0] v);
    logic [7:0] c;
    c = v;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // The first byte of a frame uses the live crc_en; later bytes use the latched copy.
  logic crc_sel;
  logic last_data;
  logic tmo_fire;

  assign crc_sel   = (state_q == S_IDLE) ? crc_en : frame_crc_q;
  assign last_data = (cnt_q == CNT_LAST);
  // A byte in the limit cycle wins over the timeout.
  assign tmo_fire  = ((state_q == S_COLLECT) || (state_q == S_CRC)) && !rx_valid && (tmo_q == TMO_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (rx_valid) begin
          if (last_data) state_d = crc_sel ? S_CRC : S_HOLD;
          else           state_d = S_COLLECT;
        end else if (tmo_fire) begin
          state_d = S_IDLE;
        end
      end
      S_CRC: begin
        if (rx_valid)      state_d = S_HOLD;
        else if (tmo_fire) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (block_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    block_out   = data_q;
    block_valid = (state_q == S_HOLD);
    busy        = (state_q != S_IDLE);
    crc_err     = crc_err_q;
    overrun     = overrun_q;
    frame_abort = abort_q;
  end

  // Datapath next values
  always_comb begin
    data_d      = data_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    crc_err_d   = crc_err_q;
    overrun_d   = (state_q == S_HOLD) && rx_valid;
    abort_d     = tmo_fire;

    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (rx_valid) begin
          // Shift in so the first byte ends up in the top lane after BLOCK_BYTES bytes.
          data_d = (data_q << 8) | BW'(rx_data);
          crc_d  = crc8(crc_q ^ rx_data);
          cnt_d  = cnt_q + CNT_W'(1);
          tmo_d  = '0;
          if (state_q == S_IDLE) frame_crc_d = crc_en;
          if (last_data && !crc_sel) crc_err_d = 1'b0;
        end else if (tmo_fire) begin
          cnt_d = '0;
          crc_d = '0;
          tmo_d = '0;
        end else if (state_q == S_COLLECT) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          crc_err_d = (rx_data != crc_q);
          tmo_d     = '0;
        end else if (tmo_fire) begin
          cnt_d = '0;
          crc_d = '0;
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_HOLD: begin
        if (block_ready) begin
          cnt_d     = '0;
          crc_d     = '0;
          tmo_d     = '0;
          crc_err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      crc_q       <= '0;
      frame_crc_q <= 1'b0;
      crc_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
      crc_err_q   <= crc_err_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
    end
  end

endmodule

// File: tb/tb_rx_block_assembler.sv
// Directed bench for rx_block_assembler: a table of whole frames plus hand
// sequences for overrun, accept-cycle drop, timeout, timeout priority and reset.
module tb_rx_block_assembler;

  localparam int TMO = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         crc_en;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         block_ready;
  logic [127:0] block_out;
  logic         block_valid;
  logic         crc_err;
  logic         overrun;
  logic         frame_abort;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  rx_block_assembler dut (
    .clk         (clk),
    .reset       (rst_n),
    .crc_en      (crc_en),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .block_ready (block_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .crc_err     (crc_err),
    .overrun     (overrun),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic         flip;     // invert crc_en after the first byte
    logic [127:0] blk;
    logic [7:0]   crcb;
    logic         exp_err;
  } vec_t;

  vec_t vt[7];

  // Reference CRC: bit-serial feedback form, MSB first, init 0.
  function automatic logic [7:0] ref_crc(input logic [127:0] blk);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 16; i++) begin
      b = blk[127 - 8*i -: 8];
      for (int j = 7; j >= 0; j--) begin
        fb = c[7] ^ b[j];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input logic [127:0] blk, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(blk[127 - 8*i -: 8]);
  endtask

  // Sends a frame and checks latency, block_out and crc_err. Returns in HOLD
  // (block_ready=0) or after acceptance (block_ready=1).
  task automatic send_frame(input string nm, input logic en, input logic flip,
                            input logic [127:0] blk, input logic [7:0] crcb,
                            input logic exp_err);
    crc_en = en;
    send_byte(blk[127:120]);
    if (flip) crc_en = ~en;
    send_range(blk, 1, 14);
    chk({nm, "_pre_valid"}, block_valid, 0);
    send_byte(blk[7:0]);
    if (en) begin
      chk({nm, "_await_crc"}, {block_valid, busy}, 2'b01);
      send_byte(crcb);
    end
    chk({nm, "_valid"}, block_valid, 1);
    chk({nm, "_block"}, block_out, blk);
    chk({nm, "_crc_err"}, crc_err, exp_err);
    if (block_ready) begin
      @(negedge clk);
      chk({nm, "_accepted"}, {block_valid, busy}, 2'b00);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  logic [127:0] held;
  int           pulses;

  initial begin
    vt[0] = '{en: 1'b1, flip: 1'b0, blk: 128'h0, crcb: 8'h00, exp_err: 1'b0};
    vt[1] = '{en: 1'b1, flip: 1'b0, blk: 128'h1, crcb: 8'h07, exp_err: 1'b0};
    vt[2] = '{en: 1'b1, flip: 1'b0, blk: 128'h1, crcb: 8'h06, exp_err: 1'b1};
    vt[3] = '{en: 1'b0, flip: 1'b0, blk: 128'h000102030405060708090A0B0C0D0E0F, crcb: 8'h55, exp_err: 1'b0};
    vt[4] = '{en: 1'b1, flip: 1'b1, blk: 128'h000102030405060708090A0B0C0D0E0F, crcb: 8'h00, exp_err: 1'b0};
    vt[4].crcb = ref_crc(vt[4].blk);
    vt[5] = '{en: 1'b0, flip: 1'b1, blk: 128'hFFEEDDCCBBAA99887766554433221100, crcb: 8'h00, exp_err: 1'b0};
    vt[6] = '{en: 1'b1, flip: 1'b0, blk: {16{8'hFF}}, crcb: 8'h00, exp_err: 1'b1};
    vt[6].crcb = ref_crc(vt[6].blk) ^ 8'h01;

    rst_n = 1'b0; crc_en = 1'b0; rx_data = 8'hA5; rx_valid = 1'b0; block_ready = 1'b1;

    // Reset held with rx_valid toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = ~rx_valid;
      chk("reset_flags", {block_valid, crc_err, overrun, frame_abort, busy}, 5'b0);
    end
    chk("reset_block", block_out, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b1;

    // Table of whole frames, downstream always ready
    for (int v = 0; v < 7; v++) begin
      send_frame($sformatf("vec%0d", v), vt[v].en, vt[v].flip, vt[v].blk, vt[v].crcb, vt[v].exp_err);
    end

    // Overrun: block held, three bytes dropped
    block_ready = 1'b0;
    send_frame("hold", 1'b0, 1'b0, 128'h101112131415161718191A1B1C1D1E1F, 8'h00, 1'b0);
    held = block_out;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0 + 8'(i));
      chk("overrun_pulse", overrun, 1);
      @(negedge clk);
      chk("overrun_single", overrun, 0);
      chk("hold_block", block_out, held);
      chk("hold_valid", block_valid, 1);
    end
    block_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {block_valid, busy}, 2'b00);
    send_frame("after_hold", 1'b0, 1'b0, 128'h2122232425262728292A2B2C2D2E2F30, 8'h00, 1'b0);

    // Byte on the accept cycle is dropped and does not start a frame
    block_ready = 1'b0;
    send_frame("acc_drop", 1'b0, 1'b0, 128'h3132333435363738393A3B3C3D3E3F40, 8'h00, 1'b0);
    @(negedge clk);
    block_ready = 1'b1;
    rx_data     = 8'h99;
    rx_valid    = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("acc_drop_overrun", overrun, 1);
    chk("acc_drop_idle", {block_valid, busy}, 2'b00);
    send_frame("after_acc_drop", 1'b0, 1'b0, 128'h4142434445464748494A4B4C4D4E4F50, 8'h00, 1'b0);

    // Timeout: 5 bytes then silence
    crc_en = 1'b0;
    send_range(128'hAAAAAAAAAA0000000000000000000000, 0, 4);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_before", {frame_abort, busy}, 2'b01);
    @(negedge clk);
    chk("tmo_abort", {frame_abort, busy}, 2'b10);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_abort) pulses++;
    end
    chk("tmo_single_pulse", pulses, 0);
    send_frame("after_tmo", 1'b0, 1'b0, 128'h5152535455565758595A5B5C5D5E5F60, 8'h00, 1'b0);

    // A byte in the limit cycle wins over the timeout
    crc_en = 1'b1;
    held = 128'h6162636465666768696A6B6C6D6E6F70;
    send_range(held, 0, 4);
    repeat (TMO - 2) @(negedge clk);
    send_byte(held[127 - 8*5 -: 8]);
    chk("tmo_priority", {frame_abort, busy}, 2'b01);
    send_range(held, 6, 15);
    chk("tmo_prio_await_crc", {block_valid, busy}, 2'b01);
    send_byte(ref_crc(held));
    chk("tmo_prio_valid", block_valid, 1);
    chk("tmo_prio_block", block_out, held);
    chk("tmo_prio_crc_err", crc_err, 0);
    @(negedge clk);

    // Reset mid-frame, during the 8th byte strobe
    crc_en = 1'b1;
    send_range(128'h7172737475767778797A7B7C7D7E7F80, 0, 6);
    @(negedge clk);
    rx_data  = 8'h78;
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_flags", {block_valid, crc_err, overrun, frame_abort, busy}, 5'b0);
    chk("midreset_block", block_out, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    held = 128'h8182838485868788898A8B8C8D8E8F90;
    send_frame("after_reset", 1'b1, 1'b0, held, ref_crc(held), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
